mem_copy_dma: RTL and testbench
===============================

// Module: mem_copy_dma
// PURPOSE
// - Block-copy initiator for the 8-bit data memory: copies LENGTH bytes from SRC to DST.
// - Sits beside the CPU core and drives the memory's read_addr/write_addr/write_data/mem_write ports.
// - A mux outside this block selects between CPU and DMA, gated by busy.
// - The memory reads combinationally and writes level-sensitively, so every memory-side output is a register.
// PARAMETERS
// - ADDR_W  8          memory address width
// - DATA_W  8          memory data width
// - LEN_W   ADDR_W+1   length/count width (max length 2^ADDR_W)
// PORTS
// - clk             in   1       system clock, rising edge
// - rst             in   1       synchronous, active-high reset
// - start           in   1       request a copy; sampled only in IDLE
// - abort           in   1       cancel the copy in progress
// - src_addr        in   ADDR_W  first source byte
// - dst_addr        in   ADDR_W  first destination byte
// - length          in   LEN_W   bytes to copy; values > 2^ADDR_W saturate to 2^ADDR_W
// - mem_read_addr   out  ADDR_W  to memory read_addr
// - mem_read_data   in   DATA_W  from memory read_data (same-cycle combinational)
// - mem_write_addr  out  ADDR_W  to memory write_addr
// - mem_write_data  out  DATA_W  to memory write_data
// - mem_write       out  1       to memory mem_write; high for exactly one cycle per byte
// - busy            out  1       high in READ and WRITE
// - done            out  1       one-cycle pulse when a copy completes (not on abort)
// - bytes_done      out  LEN_W   bytes written so far; held after completion until the next start
// BEHAVIOUR
// Reset: all outputs 0, state IDLE. Reset mid-copy stops immediately and drops mem_write at that edge.
// States: IDLE, READ, WRITE, DONE.
// - IDLE:
//   - start=1, length=0: go to DONE.
//   - start=1, length>0: latch src/dst/len, clear bytes_done, set direction, load pointers;
//     mem_read_addr <= first src pointer; go to READ.
//   - start=0: stay in IDLE.
// - READ: mem_read_data is valid this cycle. At the edge:
//   - mem_write_data <= mem_read_data
//   - mem_write_addr <= dst pointer
//   - mem_write <= 1
//   - go to WRITE
// - WRITE: memory is written this cycle. At the edge:
//   - mem_write <= 0, bytes_done += 1, remaining -= 1
//   - if remaining was 1: go to DONE
//   - else step both pointers, mem_read_addr <= next src, go to READ
// - DONE: done=1 for one cycle, then IDLE. A start in DONE is ignored.
// Timing:
// - 2 cycles per byte.
// - done is high in cycle 2*len+1 after the start edge, and in cycle 1 for length 0.
// Direction:
// - Backward iff dst > src and dst < src+len (compare at LEN_W width, no wrap).
//   Pointers then start at src+len-1 / dst+len-1 and decrement.
// - Otherwise forward, incrementing.
// - This makes overlapping copies correct, i.e. memmove semantics.
// Pointer arithmetic: modulo 2^ADDR_W. A forward copy from 0xFE of length 4 touches FE,FF,00,01.
// start while busy: ignored; inputs are not re-latched.
// abort (priority below rst, above everything else):
//   - next state IDLE, mem_write <= 0, no done pulse, bytes_done holds its value
//   - abort in the READ cycle: that byte is not written
//   - abort in the WRITE cycle: that write still completes (mem_write is already high) and is counted
// STRUCTURE
// - dma_pkg: state localparams (IDLE=0, READ=1, WRITE=2, DONE=3) and the default widths.
// - Sub-module dma_addr_ctr: loadable up/down ADDR_W pointer, instantiated once for src and once for dst.
// - The FSM, length counter and output registers live in the top module.
// TESTING
// - Forward copy: mem[10..13]=A1..A4; start src=10 dst=40 len=4.
//   -> mem[40..43]=A1..A4; done in cycle 9; bytes_done=4; exactly 4 mem_write pulses.
// - Overlap, backward: mem[20..23]=1,2,3,4; src=20 dst=22 len=4.
//   -> mem[22..25]=1,2,3,4; first write address is 25.
// - Wrap: src=FE dst=80 len=4.
//   -> reads at FE,FF,00,01; mem[80..83] match those bytes.
// - Zero length: start len=0.
//   -> no mem_write, done in cycle 1, busy never high.
// - Abort: len=8, abort on the 2nd READ cycle.
//   -> next cycle IDLE; bytes_done=1; mem[dst+1] unchanged; no done pulse.
// - Reset and start during busy: start pulsed mid-copy is ignored and the original copy completes;
//   rst asserted in a WRITE cycle -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared widths and FSM state encoding for the block-copy DMA.
package dma_pkg;

  localparam int DMA_ADDR_W = 8;
  localparam int DMA_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_addr_ctr.sv
// Loadable up/down address pointer; wraps modulo 2^W in either direction.
module dma_addr_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // Load wins over step; stepping follows the direction chosen for this copy.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (step) begin
      ptr_d = down ? (ptr_q - W'(1)) : (ptr_q + W'(1));
    end
  end

  // Pointer register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Block-copy DMA: copies a run of bytes with memmove semantics, two cycles per byte.
// Every memory-facing output is a flop because the memory reads combinationally
// and writes level-sensitively.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bytes_done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  dma_state_e        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  bytes_done_q, bytes_done_d;
  logic              dir_down_q, dir_down_d;
  logic              mem_write_q, mem_write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_write_addr_q, mem_write_addr_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

  logic [LEN_W-1:0]  len_sat, src_ext, dst_ext;
  logic [ADDR_W-1:0] len_lo, src_first, dst_first;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic              backward, ptr_load, ptr_step;

  // Decode the request: saturate length, choose direction, compute first pointers.
  always_comb begin
    len_sat   = (length > MAX_LEN) ? MAX_LEN : length;
    len_lo    = len_sat[ADDR_W-1:0];
    src_ext   = LEN_W'(src_addr);
    dst_ext   = LEN_W'(dst_addr);
    backward  = (dst_ext > src_ext) && (dst_ext < (src_ext + len_sat));
    src_first = backward ? (src_addr + len_lo - ADDR_W'(1)) : src_addr;
    dst_first = backward ? (dst_addr + len_lo - ADDR_W'(1)) : dst_addr;
  end

  dma_addr_ctr #(.W(ADDR_W)) u_src_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .step     (ptr_step),
    .down     (dir_down_q),
    .load_val (src_first),
    .ptr      (src_ptr)
  );

  dma_addr_ctr #(.W(ADDR_W)) u_dst_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .step     (ptr_step),
    .down     (dir_down_q),
    .load_val (dst_first),
    .ptr      (dst_ptr)
  );

  // Next-state logic; abort overrides the normal flow but lets a write in flight count.
  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    bytes_done_d     = bytes_done_q;
    dir_down_d       = dir_down_q;
    mem_write_d      = 1'b0;
    mem_write_addr_d = mem_write_addr_q;
    mem_write_data_d = mem_write_data_q;
    ptr_load         = 1'b0;
    ptr_step         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_sat == '0) begin
            state_d = DONE;
          end else begin
            rem_d        = len_sat;
            bytes_done_d = '0;
            dir_down_d   = backward;
            ptr_load     = 1'b1;
            state_d      = READ;
          end
        end
      end
      READ: begin
        mem_write_data_d = mem_read_data;
        mem_write_addr_d = dst_ptr;
        mem_write_d      = 1'b1;
        state_d          = WRITE;
      end
      WRITE: begin
        bytes_done_d = bytes_done_q + LEN_W'(1);
        rem_d        = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          ptr_step = 1'b1;
          state_d  = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d          = IDLE;
      mem_write_d      = 1'b0;
      ptr_load         = 1'b0;
      ptr_step         = 1'b0;
      rem_d            = rem_q;
      dir_down_d       = dir_down_q;
      mem_write_addr_d = mem_write_addr_q;
      mem_write_data_d = mem_write_data_q;
      if (state_q != WRITE) begin
        bytes_done_d = bytes_done_q;
      end
    end

    busy_d = (state_d == READ) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      rem_q            <= '0;
      bytes_done_q     <= '0;
      dir_down_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_write_addr_q <= '0;
      mem_write_data_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      bytes_done_q     <= bytes_done_d;
      dir_down_q       <= dir_down_d;
      mem_write_q      <= mem_write_d;
      mem_write_addr_q <= mem_write_addr_d;
      mem_write_data_q <= mem_write_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign mem_read_addr  = src_ptr;
  assign mem_write_addr = mem_write_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bytes_done     = bytes_done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: a byte-level memmove model predicts reads,
// writes and completion; a negedge monitor checks them as the DUT produces them.
module tb_mem_copy_dma;

  localparam int EV_NONE    = 0;
  localparam int EV_ABORT   = 1;
  localparam int EV_RESTART = 2;
  localparam int EV_RESET   = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] length;
  logic [7:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic [7:0] mem_write_addr;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic [8:0] bytes_done;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       mem_init;
  logic       mon_en;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         done_q[$];

  int checks;
  int errors;

  mem_copy_dma dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .busy           (busy),
    .done           (done),
    .bytes_done     (bytes_done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: combinational read, write on the edge while mem_write is high.
  assign mem_read_data = mem[mem_read_addr];

  // Memory write port, plus a bulk load from the reference image while mem_init is high.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      mem[mem_write_addr] <= mem_write_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads, writes or completes.
  always @(negedge clk) begin : monitor
    wr_t        w;
    logic [7:0] ra;
    int         db;
    if (mon_en) begin
      if (busy && !mem_write) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_read", 32'd1, 32'd0);
        end else begin
          ra = rd_q.pop_front();
          checkOutput("read_addr", 32'(mem_read_addr), 32'(ra));
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          checkOutput("write_addr", 32'(mem_write_addr), 32'(w.a));
          checkOutput("write_data", 32'(mem_write_data), 32'(w.d));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          db = done_q.pop_front();
          if (db >= 0) checkOutput("done_bytes", 32'(bytes_done), 32'(db));
        end
      end
    end
  end

  task automatic syncMem();
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
  endtask

  // Runs one copy, optionally disturbed by an abort, a second start or a reset in cycle ev_cycle.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [8:0] len,
                               input int ev_kind, input int ev_cycle);
    int         n, nrd, nwr, lim, done_cycle, done_cnt, mism;
    bit         back, evkill, exp_busy;
    logic [7:0] sp, dp, data;
    wr_t        w;

    n      = (len > 9'd256) ? 256 : int'(len);
    back   = (d > s) && (int'(d) < int'(s) + n);
    evkill = (ev_kind == EV_ABORT) || (ev_kind == EV_RESET);
    nrd    = n;
    nwr    = n;
    if (evkill) begin
      nrd = (ev_cycle + 1) / 2;
      nwr = ev_cycle / 2;
    end

    for (int i = 0; i < n; i++) begin
      sp = back ? 8'(int'(s) + n - 1 - i) : 8'(int'(s) + i);
      dp = back ? 8'(int'(d) + n - 1 - i) : 8'(int'(d) + i);
      if (i < nrd) rd_q.push_back(sp);
      if (i < nwr) begin
        data        = ref_mem[sp];
        ref_mem[dp] = data;
        w.a         = dp;
        w.d         = data;
        wr_q.push_back(w);
      end
    end
    if (!evkill) done_q.push_back((n == 0) ? -1 : n);

    src_addr = s;
    dst_addr = d;
    length   = len;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    done_cycle = 0;
    done_cnt   = 0;
    lim        = 2 * n + 6;
    for (int k = 1; k <= lim; k++) begin
      exp_busy = (k <= 2 * n) && !(evkill && k > ev_cycle);
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      if (done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = k;
      end
      if (k == ev_cycle) begin
        case (ev_kind)
          EV_ABORT: abort = 1'b1;
          EV_RESTART: begin
            start    = 1'b1;
            src_addr = 8'($urandom);
            dst_addr = 8'($urandom);
            length   = 9'($urandom_range(1, 20));
          end
          EV_RESET: rst = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      rst   = 1'b0;
      if (k == ev_cycle && ev_kind == EV_ABORT) begin
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_bytes_done", 32'(bytes_done), 32'(nwr));
      end
      if (k == ev_cycle && ev_kind == EV_RESET) begin
        checkOutput("reset_outputs",
                    32'({mem_read_addr, mem_write_addr, mem_write_data, mem_write, busy, done, bytes_done}),
                    32'd0);
      end
    end

    if (evkill) begin
      checkOutput("no_done", 32'(done_cnt), 32'd0);
    end else begin
      checkOutput("done_cycle", 32'(done_cycle), 32'((n == 0) ? 1 : 2 * n + 1));
      checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    end
    checkOutput("reads_left", 32'(rd_q.size()), 32'd0);
    checkOutput("writes_left", 32'(wr_q.size()), 32'd0);
    checkOutput("done_left", 32'(done_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput("mem_image", 32'(mism), 32'd0);
  endtask

  // Main sequence: reset, directed scenarios, then randomized copies.
  initial begin
    logic [7:0] s, d;
    logic [8:0] len;
    int         n, kind, evc;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    mem_init = 1'b0;
    mon_en   = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

    @(posedge clk);
    #1;
    syncMem();
    @(posedge clk);
    #1;
    checkOutput("reset_state",
                32'({mem_read_addr, mem_write_addr, mem_write_data, mem_write, busy, done, bytes_done}),
                32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] forward copy");
    ref_mem[10] = 8'hA1; ref_mem[11] = 8'hA2; ref_mem[12] = 8'hA3; ref_mem[13] = 8'hA4;
    syncMem();
    applyStimulus(8'd10, 8'd40, 9'd4, EV_NONE, 0);
    checkOutput("fwd_bytes_done", 32'(bytes_done), 32'd4);

    $display("[TB] overlapping backward copy");
    ref_mem[20] = 8'd1; ref_mem[21] = 8'd2; ref_mem[22] = 8'd3; ref_mem[23] = 8'd4;
    syncMem();
    applyStimulus(8'd20, 8'd22, 9'd4, EV_NONE, 0);

    $display("[TB] wrapping source");
    applyStimulus(8'hFE, 8'h80, 9'd4, EV_NONE, 0);

    $display("[TB] zero length");
    applyStimulus(8'd33, 8'd77, 9'd0, EV_NONE, 0);

    $display("[TB] abort on second read");
    applyStimulus(8'd50, 8'd60, 9'd8, EV_ABORT, 3);

    $display("[TB] abort on a write cycle");
    applyStimulus(8'd70, 8'd90, 9'd5, EV_ABORT, 4);

    $display("[TB] start while busy");
    applyStimulus(8'd100, 8'd120, 9'd6, EV_RESTART, 4);

    $display("[TB] reset in a write cycle");
    applyStimulus(8'd130, 8'd140, 9'd5, EV_RESET, 2);

    $display("[TB] saturating length");
    applyStimulus(8'd5, 8'd5, 9'd300, EV_NONE, 0);

    $display("[TB] randomized copies");
    for (int t = 0; t < 30; t++) begin
      s = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       d = 8'($urandom);
        1:       d = s + 8'($urandom_range(1, 6));
        default: d = s - 8'($urandom_range(1, 6));
      endcase
      len = 9'($urandom_range(0, 24));
      if ($urandom_range(0, 9) == 0) len = 9'($urandom_range(250, 511));
      n    = (len > 9'd256) ? 256 : int'(len);
      kind = EV_NONE;
      evc  = 0;
      if (n != 0 && $urandom_range(0, 3) == 0) begin
        kind = EV_ABORT;
        evc  = $urandom_range(1, 2 * n);
      end
      applyStimulus(s, d, len, kind, evc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
